// File: rtl/fifo_mc_pkg.sv
// Shared defaults and pointer arithmetic for the multi-channel FIFO.
package fifo_mc_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_PTR_WIDTH    = 4;
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_AFULL_THRESH = 12;

  // Occupancy from wrap-bit pointers: difference modulo 2**(ptr_width+1).
  function automatic int unsigned ptr_count(input int unsigned wptr,
                                            input int unsigned rptr,
                                            input int unsigned ptr_width);
    return (wptr - rptr) & ((32'd1 << (ptr_width + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_mem_mc_if.sv
// Request/response bundle of the multi-channel FIFO; master drives requests, slave returns flags and data.
interface fifo_mem_mc_if
  import fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PTR_WIDTH  = DEF_PTR_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH
);
  localparam int CH_WIDTH = $clog2(NUM_CH);

  logic                            w_en;
  logic [CH_WIDTH-1:0]             w_ch;
  logic [DATA_WIDTH-1:0]           data_in;
  logic                            r_en;
  logic [CH_WIDTH-1:0]             r_ch;
  logic [NUM_CH-1:0]               flush;
  logic [DATA_WIDTH-1:0]           data_out;
  logic                            r_valid;
  logic [NUM_CH-1:0]               full;
  logic [NUM_CH-1:0]               empty;
  logic [NUM_CH-1:0]               almost_full;
  logic [NUM_CH*(PTR_WIDTH+1)-1:0] count;
  logic [NUM_CH-1:0]               overflow;
  logic [NUM_CH-1:0]               underflow;

  modport master (
    output w_en, w_ch, data_in, r_en, r_ch, flush,
    input  data_out, r_valid, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  w_en, w_ch, data_in, r_en, r_ch, flush,
    output data_out, r_valid, full, empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ch_ctrl.sv
// Pointer/flag controller for one FIFO channel.
// Latency: pointers and flags update on the clock after an accepted request.
// Backpressure: writes refused while full, reads refused while empty; clr beats both.
module fifo_ch_ctrl
  import fifo_mc_pkg::*;
#(
  parameter int PTR_WIDTH    = DEF_PTR_WIDTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 rd,
  input  logic                 clr,
  output logic                 w_acc,
  output logic                 r_acc,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH-1:0] raddr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int CW = PTR_WIDTH + 1;

  logic [PTR_WIDTH:0] wptr, rptr;

  assign empty       = (wptr == rptr);
  assign full        = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                       (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
  assign count       = CW'(ptr_count(32'(wptr), 32'(rptr), PTR_WIDTH));
  assign almost_full = (count >= CW'(AFULL_THRESH));
  assign waddr       = wptr[PTR_WIDTH-1:0];
  assign raddr       = rptr[PTR_WIDTH-1:0];

  // Acceptance is judged on the registered pointers, so a full channel still takes a read.
  assign w_acc = wr && !full  && !clr;
  assign r_acc = rd && !empty && !clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_acc) wptr <= wptr + 1'b1;
      if (r_acc) rptr <= rptr + 1'b1;
      if (wr && full)  overflow  <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_mem_mc.sv
// NUM_CH circular queues sharing one RAM, with per-channel flags, counts and sticky errors.
// Latency: read data and r_valid registered, one cycle after an accepted read; no write-to-read bypass.
// Backpressure: none upstream; full/empty/almost_full are exported and refused requests set sticky flags.
module fifo_mem_mc
  import fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PTR_WIDTH    = DEF_PTR_WIDTH,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
  input  logic          clk,
  input  logic          rst,
  fifo_mem_mc_if.slave  bus
);
  localparam int DEPTH    = 2 ** PTR_WIDTH;
  localparam int CH_WIDTH = $clog2(NUM_CH);

  logic [NUM_CH-1:0]     wr, rd, w_acc, r_acc;
  logic [NUM_CH-1:0]     full_v, empty_v, afull_v, ovf_v, udf_v;
  logic [PTR_WIDTH-1:0]  waddr [NUM_CH];
  logic [PTR_WIDTH-1:0]  raddr [NUM_CH];
  logic [PTR_WIDTH:0]    ch_count [NUM_CH];
  logic [PTR_WIDTH-1:0]  wsel, rsel;
  logic [DATA_WIDTH-1:0] mem [(2**CH_WIDTH)*DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rvalid_q;

  // Channel decode only matches real channels, so out-of-range selects touch nothing.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr[c] = bus.w_en && (bus.w_ch == CH_WIDTH'(c));
    assign rd[c] = bus.r_en && (bus.r_ch == CH_WIDTH'(c));

    fifo_ch_ctrl #(
      .PTR_WIDTH    (PTR_WIDTH),
      .AFULL_THRESH (AFULL_THRESH)
    ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .wr          (wr[c]),
      .rd          (rd[c]),
      .clr         (bus.flush[c]),
      .w_acc       (w_acc[c]),
      .r_acc       (r_acc[c]),
      .waddr       (waddr[c]),
      .raddr       (raddr[c]),
      .full        (full_v[c]),
      .empty       (empty_v[c]),
      .almost_full (afull_v[c]),
      .count       (ch_count[c]),
      .overflow    (ovf_v[c]),
      .underflow   (udf_v[c])
    );

    assign bus.count[c*(PTR_WIDTH+1) +: PTR_WIDTH+1] = ch_count[c];
  end

  always_comb begin
    wsel = '0;
    rsel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr[c]) wsel = waddr[c];
      if (rd[c]) rsel = raddr[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (|w_acc)) mem[{bus.w_ch, wsel}] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= |r_acc;
      if (|r_acc) dout_q <= mem[{bus.r_ch, rsel}];
    end
  end

  assign bus.data_out    = dout_q;
  assign bus.r_valid     = rvalid_q;
  assign bus.full        = full_v;
  assign bus.empty       = empty_v;
  assign bus.almost_full = afull_v;
  assign bus.overflow    = ovf_v;
  assign bus.underflow   = udf_v;

endmodule
